// File: rtl/rand_port_arbiter.sv
// Round-robin arbiter sharing one random-buffer read port among NREQ requesters.
// Latency: request sampled at T -> rand_rd at T+1 -> out_valid pulse at T+3; one word per 4 cycles.
// Backpressure: waits in IDLE while rand_ready is low; req/rand_ready changes mid-transfer are ignored.
module rand_port_arbiter #(
   parameter int NREQ     = 4,
   parameter int DATA_WID = 32,
   parameter int CNT_WID  = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          out_valid,
   output logic [DATA_WID-1:0]      out_data,
   output logic                     rand_rd,
   input  logic                     rand_ready,
   input  logic [DATA_WID-1:0]      rand_data,
   output logic                     busy,
   output logic [NREQ*CNT_WID-1:0]  gnt_cnt
);

   localparam int PTR_WID = $clog2(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_CAP  = 2'd2,
      ST_DLV  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PTR_WID-1:0]    r_rr_ptr;
   logic [PTR_WID-1:0]    r_win;
   logic [PTR_WID-1:0]    w_winner;
   logic                  w_found;
   logic                  w_grant;
   int                    w_sum;
   logic [NREQ-1:0]       w_onehot;
   logic [NREQ-1:0]       r_out_valid;
   logic                  r_rand_rd;
   logic                  r_busy;
   logic [DATA_WID-1:0]   r_data_q;
   logic [CNT_WID-1:0]    r_cnt [NREQ];

   // Round-robin search: first set req bit after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_rr_ptr;
      w_sum    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_sum = int'(r_rr_ptr) + k;
         if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
         end
         if (!w_found && req[PTR_WID'(w_sum)]) begin
            w_found  = 1'b1;
            w_winner = PTR_WID'(w_sum);
         end
      end
   end

   assign w_grant = (r_state == ST_IDLE) && w_found && rand_ready;

   // Next-state logic; the transfer runs RD -> CAP -> DLV without any abort path.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_grant) w_state_nxt = ST_RD;
         ST_RD:   w_state_nxt = ST_CAP;
         ST_CAP:  w_state_nxt = ST_DLV;
         ST_DLV:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // One-hot decode of the latched winner, used to form the delivery pulse.
   always_comb begin
      w_onehot        = '0;
      w_onehot[r_win] = 1'b1;
   end

   // State register and registered control outputs, all derived from the next state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_rand_rd   <= 1'b0;
         r_out_valid <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_rand_rd   <= (w_state_nxt == ST_RD);
         r_out_valid <= (w_state_nxt == ST_DLV) ? w_onehot : '0;
      end
   end

   // Winner latch and round-robin pointer; pointer resets to NREQ-1 so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_win    <= '0;
         r_rr_ptr <= PTR_WID'(NREQ - 1);
      end else if (w_grant) begin
         r_win    <= w_winner;
         r_rr_ptr <= w_winner;
      end
   end

   // Capture the buffer word at the end of CAP; it also holds as out_data between pulses.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_data_q <= '0;
      end else if (r_state == ST_CAP) begin
         r_data_q <= rand_data;
      end
   end

   // Per-requester delivery counters, bumped at the end of DLV and wrapping freely.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NREQ; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (r_state == ST_DLV) begin
         r_cnt[r_win] <= r_cnt[r_win] + CNT_WID'(1);
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_cnt_pack
      assign gnt_cnt[g*CNT_WID +: CNT_WID] = r_cnt[g];
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_data_q;
   assign rand_rd   = r_rand_rd;
   assign busy      = r_busy;

endmodule
